uart_rx_ascii_check: RTL and testbench

UART_RX_ASCII_CHECK -- requirements
Module: uart_rx_ascii_check

---
 rtl/uart_rx_ascii_check_pkg.sv | 14 +
 rtl/uart_rx_ascii_check_if.sv | 11 +
 rtl/uart_rx_ascii_check_baud.sv | 27 ++
 rtl/uart_rx_ascii_check.sv | 138 +++++++++++++
 tb/tb_uart_rx_ascii_check.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_ascii_check_pkg.sv
// Shared constants and FSM encoding for the ASCII-sequence UART receiver.
package uart_rx_ascii_check_pkg;

   localparam logic [7:0] ASCII_A = 8'd97;
   localparam logic [7:0] ASCII_Z = 8'd122;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_e;

endpackage

// File: rtl/uart_rx_ascii_check_if.sv
// Link between the receive FSM and its bit timer: clear request in, bit ticks out.
interface uart_rx_ascii_check_if;

   logic clr;
   logic half_tick;
   logic full_tick;

   modport master (output clr, input half_tick, input full_tick);
   modport slave  (input clr, output half_tick, output full_tick);

endinterface

// File: rtl/uart_rx_ascii_check_baud.sv
// Bit timer: free-running count modulo CPB, restarted by clr; flags half- and full-bit points.
module uart_rx_baud #(
   parameter int CPB = 1250
) (
   input  logic                  clk,
   input  logic                  rst_n,
   uart_rx_ascii_check_if.slave  bif
);

   localparam int TW = (CPB > 1) ? $clog2(CPB) : 1;

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (bif.clr || cnt_q == TW'(CPB - 1)) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign bif.half_tick = (cnt_q == TW'(CPB / 2 - 1));
   assign bif.full_tick = (cnt_q == TW'(CPB - 1));

endmodule

// File: rtl/uart_rx_ascii_check.sv
// 8N1 UART receiver that checks incoming bytes follow the FIRST..LIMIT character sequence.
module uart_rx_ascii_check
   import uart_rx_ascii_check_pkg::*;
#(
   parameter int              CLK_FREQ = 12000000,
   parameter int              BAUD     = 9600,
   parameter int              SIZE     = 8,
   parameter logic [SIZE-1:0] FIRST    = ASCII_A,
   parameter logic [SIZE-1:0] LIMIT    = ASCII_Z
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            rx,
   output logic [SIZE-1:0] word,
   output logic            valid,
   output logic            frame_err,
   output logic            seq_err,
   output logic [7:0]      err_count
);

   localparam int CPB = CLK_FREQ / BAUD;
   localparam int IW  = (SIZE > 1) ? $clog2(SIZE) : 1;

   logic            sync1_q, rx_s_q;
   rx_state_e       state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [SIZE-1:0] shift_q, shift_d;
   logic [SIZE-1:0] word_q, word_d;
   logic [SIZE-1:0] exp_q, exp_d;
   logic            valid_q, valid_d;
   logic            frame_err_q, frame_err_d;
   logic            seq_err_q, seq_err_d;
   logic [7:0]      err_cnt_q, err_cnt_d;

   uart_rx_ascii_check_if bif ();

   uart_rx_baud #(.CPB(CPB)) u_baud (
      .clk   (clk),
      .rst_n (rst_n),
      .bif   (bif.slave)
   );

   // Timer holds at zero while idle and restarts at the start-bit midpoint,
   // so every later full tick lands mid-bit.
   assign bif.clr = (state_q == IDLE) || (state_q == START && bif.half_tick);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
      end else begin
         sync1_q <= rx;
         rx_s_q  <= sync1_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      word_d      = word_q;
      exp_d       = exp_q;
      err_cnt_d   = err_cnt_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      seq_err_d   = 1'b0;

      case (state_q)
         IDLE:
            if (!rx_s_q) state_d = START;
         START:
            if (bif.half_tick) begin
               if (!rx_s_q) begin
                  state_d = DATA;
                  idx_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         DATA:
            if (bif.full_tick) begin
               shift_d[idx_q] = rx_s_q;
               if (idx_q == IW'(SIZE - 1)) state_d = STOP;
               else                        idx_d   = idx_q + 1'b1;
            end
         STOP:
            if (bif.full_tick) begin
               state_d = IDLE;
               if (rx_s_q) begin
                  word_d    = shift_q;
                  valid_d   = 1'b1;
                  seq_err_d = (shift_q != exp_q);
                  // Anything outside the sequence range restarts it from FIRST.
                  if (shift_q >= FIRST && shift_q < LIMIT) exp_d = shift_q + 1'b1;
                  else                                     exp_d = FIRST;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         default:
            state_d = IDLE;
      endcase

      if ((seq_err_d || frame_err_d) && err_cnt_q != 8'hFF)
         err_cnt_d = err_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         shift_q     <= '0;
         word_q      <= '0;
         exp_q       <= FIRST;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         seq_err_q   <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         word_q      <= word_d;
         exp_q       <= exp_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         seq_err_q   <= seq_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign word      = word_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign seq_err   = seq_err_q;
   assign err_count = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_ascii_check.sv
// Directed bench: table of frames with expected pulses/word/err_count, plus glitch, reset-abort and saturation sequences.
module tb_uart_rx_ascii_check;
   import uart_rx_ascii_check_pkg::*;

   // 9600 baud with 8 clocks per bit keeps the whole run short.
   localparam int BAUD     = 9600;
   localparam int CPB      = 8;
   localparam int CLK_FREQ = BAUD * CPB;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic [7:0] word;
   logic       valid, frame_err, seq_err;
   logic [7:0] err_count;

   uart_rx_ascii_check #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD),
      .SIZE     (8),
      .FIRST    (8'd97),
      .LIMIT    (8'd122)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .word      (word),
      .valid     (valid),
      .frame_err (frame_err),
      .seq_err   (seq_err),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Cumulative pulse counters; the test diffs snapshots around each frame.
   int nv = 0, nf = 0, ns = 0, nb = 0;
   always @(negedge clk) begin
      if (valid)              nv++;
      if (frame_err)          nf++;
      if (seq_err)            ns++;
      if (seq_err && !valid)  nb++;
   end

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         gap;
      logic       rst_before;
      int         exp_valid;
      int         exp_ferr;
      int         exp_seq;
      logic [7:0] exp_word;
      logic [7:0] exp_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(logic [7:0] d, logic stop, int gap, logic rst_b,
                               logic [7:0] w, int sq, logic [7:0] cnt);
      vec_t v;
      v.data = d; v.stop = stop; v.gap = gap; v.rst_before = rst_b;
      v.exp_valid = stop ? 1 : 0;
      v.exp_ferr  = stop ? 0 : 1;
      v.exp_seq = sq; v.exp_word = w; v.exp_cnt = cnt;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop);
      logic [9:0] bits;
      bits = {stop, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = bits[i];
         repeat (CPB) @(negedge clk);
      end
      rx = 1'b1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   int s_v, s_f, s_s, s_b;
   task automatic snap();
      s_v = nv; s_f = nf; s_s = ns; s_b = nb;
   endtask

   initial begin
      rst_n = 1'b0;
      rx    = 1'b1;

      // Group 1: full 'a'..'z' run and wrap back to 'a', frames back-to-back.
      add(8'd97, 1'b1, 0, 1'b1, 8'd97, 0, 8'd0);
      for (int c = 98; c <= 122; c++) add(8'(c), 1'b1, 0, 1'b0, 8'(c), 0, 8'd0);
      add(8'd97, 1'b1, 2 * CPB, 1'b0, 8'd97, 0, 8'd0);
      // Group 2: skipped 'c'; 'e' follows 'd' cleanly.
      add(8'd97,  1'b1, 0, 1'b1, 8'd97,  0, 8'd0);
      add(8'd98,  1'b1, 0, 1'b0, 8'd98,  0, 8'd0);
      add(8'd100, 1'b1, 0, 1'b0, 8'd100, 1, 8'd1);
      add(8'd101, 1'b1, 0, 1'b0, 8'd101, 0, 8'd1);
      // Group 3: out-of-range chars resync, bad stop leaves word/expected alone.
      add(8'h41,  1'b1, 0,       1'b1, 8'h41,  1, 8'd1);
      add(8'd97,  1'b1, 0,       1'b0, 8'd97,  0, 8'd1);
      add(8'd99,  1'b0, 2 * CPB, 1'b0, 8'd97,  0, 8'd2);
      add(8'd98,  1'b1, 0,       1'b0, 8'd98,  0, 8'd2);
      add(8'd123, 1'b1, 0,       1'b0, 8'd123, 1, 8'd3);
      add(8'd97,  1'b1, 0,       1'b0, 8'd97,  0, 8'd3);

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      check("reset word",      32'(word),      32'd0);
      check("reset valid",     32'(valid),     32'd0);
      check("reset frame_err", 32'(frame_err), 32'd0);
      check("reset seq_err",   32'(seq_err),   32'd0);
      check("reset err_count", 32'(err_count), 32'd0);

      foreach (vecs[i]) begin
         if (vecs[i].rst_before) do_reset();
         snap();
         send_byte(vecs[i].data, vecs[i].stop);
         repeat (vecs[i].gap) @(negedge clk);
         check($sformatf("row%0d valid", i),     32'(nv - s_v), 32'(vecs[i].exp_valid));
         check($sformatf("row%0d frame_err", i), 32'(nf - s_f), 32'(vecs[i].exp_ferr));
         check($sformatf("row%0d seq_err", i),   32'(ns - s_s), 32'(vecs[i].exp_seq));
         check($sformatf("row%0d seq_alone", i), 32'(nb - s_b), 32'd0);
         check($sformatf("row%0d word", i),      32'(word),      32'(vecs[i].exp_word));
         check($sformatf("row%0d err_count", i), 32'(err_count), 32'(vecs[i].exp_cnt));
      end

      // Short low glitch in idle must be rejected at the start-bit midpoint.
      snap();
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check("glitch valid",     32'(nv - s_v), 32'd0);
      check("glitch frame_err", 32'(nf - s_f), 32'd0);
      check("glitch state",     32'(dut.state_q), 32'(IDLE));
      snap();
      send_byte(8'd98, 1'b1);
      check("post-glitch valid",   32'(nv - s_v), 32'd1);
      check("post-glitch seq_err", 32'(ns - s_s), 32'd0);
      check("post-glitch word",    32'(word),     32'd98);

      // Reset during bit 4 of 'x' aborts the frame silently.
      snap();
      begin
         logic [9:0] bits;
         bits = {1'b1, 8'h78, 1'b0};
         for (int i = 0; i < 5; i++) begin
            rx = bits[i];
            repeat (CPB) @(negedge clk);
         end
         rx = bits[5];
         repeat (CPB / 2) @(negedge clk);
      end
      do_reset();
      repeat (2 * CPB) @(negedge clk);
      check("abort valid",     32'(nv - s_v), 32'd0);
      check("abort frame_err", 32'(nf - s_f), 32'd0);
      check("abort seq_err",   32'(ns - s_s), 32'd0);
      check("abort state",     32'(dut.state_q), 32'(IDLE));
      snap();
      send_byte(8'd97, 1'b1);
      check("after-abort valid",   32'(nv - s_v), 32'd1);
      check("after-abort seq_err", 32'(ns - s_s), 32'd0);
      check("after-abort word",    32'(word),     32'd97);
      check("after-abort errcnt",  32'(err_count), 32'd0);

      // err_count saturation via repeated framing errors.
      do_reset();
      snap();
      for (int i = 0; i < 254; i++) begin
         send_byte(8'h00, 1'b0);
         repeat (2 * CPB) @(negedge clk);
      end
      check("sat 254 count",     32'(err_count), 32'd254);
      check("sat frame pulses",  32'(nf - s_f),  32'd254);
      check("sat no valid",      32'(nv - s_v),  32'd0);
      check("sat word kept",     32'(word),      32'd0);
      send_byte(8'h00, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      check("sat 255 count", 32'(err_count), 32'd255);
      send_byte(8'h00, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      check("sat hold count", 32'(err_count), 32'd255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
